// File: rtl/auth_session_ctrl_if.sv
// Bundle of card-reader, keypad, admin and Authenticator signals around the session sequencer.
// master drives the sequencer inputs; slave is the sequencer itself.
interface auth_session_ctrl_if #(
  parameter int MAX_TRIES = 3
);
  localparam int TRIES_W = ($clog2(MAX_TRIES + 1) < 2) ? 2 : $clog2(MAX_TRIES + 1);

  logic               card_valid;
  logic [3:0]         acc_num_in;
  logic               pin_valid;
  logic [15:0]        pin_in;
  logic               cancel;
  logic               logout;
  logic               unlock_req;
  logic [3:0]         unlock_idx;
  logic               acc_found_stat;
  logic               acc_auth_stat;
  logic [3:0]         acc_index_in;
  logic [3:0]         auth_acc_num;
  logic [15:0]        auth_pin;
  logic               session_active;
  logic [3:0]         acc_index_out;
  logic               done;
  logic [2:0]         status;
  logic [TRIES_W-1:0] tries_left;

  modport master (
    output card_valid, acc_num_in, pin_valid, pin_in, cancel, logout,
           unlock_req, unlock_idx, acc_found_stat, acc_auth_stat, acc_index_in,
    input  auth_acc_num, auth_pin, session_active, acc_index_out, done, status, tries_left
  );

  modport slave (
    input  card_valid, acc_num_in, pin_valid, pin_in, cancel, logout,
           unlock_req, unlock_idx, acc_found_stat, acc_auth_stat, acc_index_in,
    output auth_acc_num, auth_pin, session_active, acc_index_out, done, status, tries_left
  );
endinterface

// File: rtl/auth_session_ctrl.sv
// Session sequencer in front of the Authenticator: card lookup, PIN retries with lockout,
// idle-PIN timeout and a granted session held until logout/cancel.
module auth_session_ctrl #(
  parameter int NUM_ACCOUNTS   = 10,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                clk,
  input logic                rst,
  auth_session_ctrl_if.slave bus
);
  localparam int TRIES_W = ($clog2(MAX_TRIES + 1) < 2) ? 2 : $clog2(MAX_TRIES + 1);
  localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX  = TRIES_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] STATUS_OK        = 3'd0;
  localparam logic [2:0] STATUS_NOT_FOUND = 3'd1;
  localparam logic [2:0] STATUS_BAD_PIN   = 3'd2;
  localparam logic [2:0] STATUS_LOCKED    = 3'd3;
  localparam logic [2:0] STATUS_TIMEOUT   = 3'd4;
  localparam logic [2:0] STATUS_CANCELLED = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WAIT_PIN, ST_CHECK, ST_GRANTED
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              acc_num_reg, acc_num_next;
  logic [15:0]             pin_reg, pin_next;
  logic [3:0]              idx_reg, idx_next;
  logic [TIMER_W-1:0]      timer_reg, timer_next;
  logic [TRIES_W-1:0]      fail_reg, fail_next;
  logic [TRIES_W-1:0]      tries_reg, tries_next;
  logic                    done_reg, done_next;
  logic [2:0]              status_reg, status_next;
  logic [NUM_ACCOUNTS-1:0] lock_reg, lock_next;
  logic [NUM_ACCOUNTS-1:0] lock_sel;
  logic                    lock_hit;
  logic                    lock_set;
  logic [TRIES_W-1:0]      fail_inc;

  // A lock raised by the final failed PIN takes precedence over an admin unlock of the same account.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_lock
      assign lock_sel[gi]  = lock_reg[gi] && (bus.acc_index_in == 4'(gi));
      assign lock_next[gi] = (lock_set && (idx_reg == 4'(gi)))                ? 1'b1 :
                             (bus.unlock_req && (bus.unlock_idx == 4'(gi)))  ? 1'b0 :
                                                                                lock_reg[gi];
    end
  endgenerate

  assign lock_hit = |lock_sel;
  assign fail_inc = fail_reg + TRIES_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      acc_num_reg <= '0;
      pin_reg     <= '0;
      idx_reg     <= '0;
      timer_reg   <= '0;
      fail_reg    <= '0;
      tries_reg   <= TRIES_MAX;
      done_reg    <= 1'b0;
      status_reg  <= STATUS_OK;
      lock_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      acc_num_reg <= acc_num_next;
      pin_reg     <= pin_next;
      idx_reg     <= idx_next;
      timer_reg   <= timer_next;
      fail_reg    <= fail_next;
      tries_reg   <= tries_next;
      done_reg    <= done_next;
      status_reg  <= status_next;
      lock_reg    <= lock_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_num_next = acc_num_reg;
    pin_next     = pin_reg;
    idx_next     = idx_reg;
    timer_next   = timer_reg;
    fail_next    = fail_reg;
    tries_next   = tries_reg;
    done_next    = 1'b0;
    status_next  = status_reg;
    lock_set     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.card_valid) begin
          acc_num_next = bus.acc_num_in;
          state_next   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!bus.acc_found_stat || lock_hit) begin
          done_next   = 1'b1;
          status_next = bus.acc_found_stat ? STATUS_LOCKED : STATUS_NOT_FOUND;
          state_next  = ST_IDLE;
        end else begin
          idx_next   = bus.acc_index_in;
          fail_next  = '0;
          tries_next = TRIES_MAX;
          timer_next = '0;
          state_next = ST_WAIT_PIN;
        end
      end
      ST_WAIT_PIN: begin
        if (bus.cancel) begin
          done_next   = 1'b1;
          status_next = STATUS_CANCELLED;
          state_next  = ST_IDLE;
        end else if (bus.pin_valid) begin
          pin_next   = bus.pin_in;
          state_next = ST_CHECK;
        end else if (timer_reg == TIMER_LAST) begin
          done_next   = 1'b1;
          status_next = STATUS_TIMEOUT;
          state_next  = ST_IDLE;
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      ST_CHECK: begin
        done_next = 1'b1;
        if (bus.acc_auth_stat) begin
          status_next = STATUS_OK;
          fail_next   = '0;
          tries_next  = TRIES_MAX;
          state_next  = ST_GRANTED;
        end else if (fail_inc < TRIES_MAX) begin
          status_next = STATUS_BAD_PIN;
          fail_next   = fail_inc;
          tries_next  = TRIES_MAX - fail_inc;
          timer_next  = '0;
          state_next  = ST_WAIT_PIN;
        end else begin
          lock_set    = 1'b1;
          status_next = STATUS_LOCKED;
          state_next  = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (bus.logout || bus.cancel) begin
          done_next   = 1'b1;
          status_next = STATUS_OK;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The PIN is never retained outside an attempt, and the retry budget restarts with each card.
    if (state_next == ST_IDLE && state_reg != ST_IDLE) begin
      pin_next   = '0;
      fail_next  = '0;
      tries_next = TRIES_MAX;
    end
  end

  assign bus.auth_acc_num   = acc_num_reg;
  assign bus.auth_pin       = pin_reg;
  assign bus.session_active = (state_reg == ST_GRANTED);
  assign bus.acc_index_out  = idx_reg;
  assign bus.done           = done_reg;
  assign bus.status         = status_reg;
  assign bus.tries_left     = tries_reg;
endmodule
